// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

  // Framing FSM: hunt for sync, take the length, stream data, verify checksum
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } state_t;

  // Byte receiver: hunt for a start edge, confirm it, shift bits, sample stop
  typedef enum logic [1:0] {
    RX_HUNT,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Wide enough to count the eight data bits of one character
  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/prog_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizes rx, times each bit from the start
// edge, and emits one byte_valid pulse per character at the stop sample.
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_ok
);

  localparam int TIMER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  rx_state_t            state_q;
  rx_state_t            state_d;
  logic [TIMER_W-1:0]   timer_q;
  logic [TIMER_W-1:0]   timer_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_d;
  logic [7:0]           shift_q;
  logic [7:0]           shift_d;
  logic                 valid_d;
  logic [7:0]           byte_d;
  logic                 ok_d;

  // Two-flop synchronizer for the async line plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Next-state logic: bit timing is measured from the detected start edge
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    byte_d    = rx_byte;
    ok_d      = frame_ok;
    case (state_q)
      RX_HUNT: begin
        timer_d = '0;
        if (rx_prev && !rx_sync) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_sync ? RX_HUNT : RX_BITS;
        end
      end
      RX_BITS: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          shift_d   = {rx_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_CNT_W'(7)) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          valid_d = 1'b1;
          byte_d  = shift_q;
          ok_d    = rx_sync;
          state_d = RX_HUNT;
        end
      end
      default: begin
        state_d = RX_HUNT;
      end
    endcase
  end

  // Receiver state and registered byte outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_HUNT;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_ok   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      rx_byte    <= byte_d;
      frame_ok   <= ok_d;
    end
  end

endmodule

// File: rtl/prog_loader_uart.sv
// Program loader: parses SYNC/LEN/DATA/CSUM frames from the UART, writes the
// image into instruction memory, and releases the core only after a good checksum.
module prog_loader_uart
  import prog_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         ADDR_W       = 7,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              inst_we,
  output logic [ADDR_W-1:0] inst_address,
  output logic [7:0]        inst_data,
  output logic              cpu_rst_n,
  output logic              loading,
  output logic              error
);

  // Remaining-byte counter must hold both any LEN value and the full depth
  localparam int CNT_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
  localparam logic [CNT_W-1:0] FULL_DEPTH = CNT_W'(2 ** ADDR_W);

  logic              byte_valid;
  logic [7:0]        rx_byte;
  logic              frame_ok;
  logic              is_sync;
  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  remain_q;
  logic [CNT_W-1:0]  remain_d;
  logic [7:0]        sum_q;
  logic [7:0]        sum_d;
  logic              we_d;
  logic [ADDR_W-1:0] address_d;
  logic [7:0]        data_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_ok  (frame_ok)
  );

  assign is_sync = byte_valid && frame_ok && (rx_byte == SYNC_BYTE);

  // Frame parser; the move to CSUM waits for the last write strobe so inst_we stays within DATA
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    sum_d     = sum_q;
    we_d      = 1'b0;
    address_d = inst_address;
    data_d    = inst_data;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (is_sync) begin
          state_d = ST_LEN;
          addr_d  = '0;
          sum_d   = '0;
        end
      end
      ST_LEN: begin
        if (byte_valid) begin
          if (!frame_ok) begin
            state_d = ST_ERROR;
          end else begin
            remain_d = (rx_byte == 8'd0) ? FULL_DEPTH : CNT_W'(rx_byte);
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          if (!frame_ok) begin
            state_d = ST_ERROR;
          end else begin
            we_d      = 1'b1;
            address_d = addr_q;
            data_d    = rx_byte;
            addr_d    = addr_q + 1'b1;
            sum_d     = sum_q + rx_byte;
            remain_d  = remain_q - 1'b1;
          end
        end else if (inst_we && (remain_q == '0)) begin
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (byte_valid) begin
          state_d = (frame_ok && (rx_byte == sum_q)) ? ST_RUN : ST_ERROR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loader state plus registered memory port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      sum_q        <= '0;
      inst_we      <= 1'b0;
      inst_address <= '0;
      inst_data    <= '0;
      cpu_rst_n    <= 1'b0;
      loading      <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      sum_q        <= sum_d;
      inst_we      <= we_d;
      inst_address <= address_d;
      inst_data    <= data_d;
      cpu_rst_n    <= (state_d == ST_RUN);
      loading      <= (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
      error        <= (state_d == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_prog_loader_uart.sv
// Bench for prog_loader_uart: serializes frames onto rx and compares the
// memory writes and status outputs against a frame-level reference model.
module tb_prog_loader_uart;

  localparam int         CPB    = 4;
  localparam int         ADDR_W = 7;
  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx;
  logic              inst_we;
  logic [ADDR_W-1:0] inst_address;
  logic [7:0]        inst_data;
  logic              cpu_rst_n;
  logic              loading;
  logic              error;

  int checks = 0;
  int errors = 0;
  int we_outside = 0;

  logic [ADDR_W+7:0] obs_writes[$];
  logic [ADDR_W+7:0] exp_writes[$];
  logic [7:0]        payload[$];

  always #5 clk = ~clk;

  prog_loader_uart #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .inst_we     (inst_we),
    .inst_address(inst_address),
    .inst_data   (inst_data),
    .cpu_rst_n   (cpu_rst_n),
    .loading     (loading),
    .error       (error)
  );

  // Record every write strobe cycle; a strobe while not loading is illegal
  always @(negedge clk) begin
    if (rst_n && inst_we) begin
      obs_writes.push_back({inst_address, inst_data});
      if (!loading) we_outside++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Serialize one 8N1 character starting at a falling clock edge
  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, value, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    if (!stop_bit) begin
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  function automatic logic [7:0] model_sum();
    int total;
    total = 0;
    foreach (payload[i]) total += int'(payload[i]);
    return 8'(total % 256);
  endfunction

  task automatic check_writes(input string tag);
    int bad;
    bad = 0;
    checkOutput({tag, "_write_count"}, 32'(obs_writes.size()), 32'(exp_writes.size()));
    for (int i = 0; i < exp_writes.size() && i < obs_writes.size(); i++) begin
      if (obs_writes[i] !== exp_writes[i]) bad++;
    end
    checkOutput({tag, "_write_content_bad"}, 32'(bad), 32'd0);
  endtask

  // Send SYNC, LEN, payload, CSUM and compare against the model's outcome
  task automatic send_frame(input string tag, input logic [7:0] len_byte,
                            input logic [7:0] csum_byte, input int glitch_at);
    logic good;
    good = (csum_byte == model_sum());
    exp_writes.delete();
    foreach (payload[i]) exp_writes.push_back({ADDR_W'(i % DEPTH), payload[i]});
    obs_writes.delete();
    applyStimulus(SYNC, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_loading_after_sync"}, 32'(loading), 32'd1);
    checkOutput({tag, "_cpu_held_after_sync"}, 32'(cpu_rst_n), 32'd0);
    applyStimulus(len_byte, 1'b1);
    foreach (payload[i]) begin
      applyStimulus(payload[i], 1'b1);
      if (i == glitch_at) begin
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (6 * CPB) @(negedge clk);
      end
    end
    checkOutput({tag, "_loading_before_csum"}, 32'(loading), 32'd1);
    applyStimulus(csum_byte, 1'b1);
    repeat (4) @(negedge clk);
    check_writes(tag);
    checkOutput({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(good));
    checkOutput({tag, "_error"}, 32'(error), 32'(!good));
    checkOutput({tag, "_loading_end"}, 32'(loading), 32'd0);
  endtask

  initial begin
    logic [7:0] csum;
    logic [7:0] flip;
    int         len;
    $display("[TB] prog_loader_uart bench start");
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("reset_inst_we", 32'(inst_we), 32'd0);
    checkOutput("reset_loading", 32'(loading), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    checkOutput("reset_inst_address", 32'(inst_address), 32'd0);
    checkOutput("reset_inst_data", 32'(inst_data), 32'd0);

    // Idle line for a long time must not disturb anything
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    checkOutput("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("idle_loading", 32'(loading), 32'd0);
    checkOutput("idle_writes", 32'(obs_writes.size()), 32'd0);

    // A sync byte with a bad stop bit while idle is ignored
    applyStimulus(SYNC, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("idle_framing_loading", 32'(loading), 32'd0);
    checkOutput("idle_framing_error", 32'(error), 32'd0);

    // Directed good frame
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame("good3", 8'h03, 8'h66, -1);

    // Bad checksum, then a good resend clears the error
    payload = '{8'h10, 8'h20};
    send_frame("badsum", 8'h02, 8'h31, -1);
    payload = '{8'h7F};
    send_frame("resend", 8'h01, 8'h7F, -1);

    // Framing error on a data byte: no write for it, ERROR state
    obs_writes.delete();
    applyStimulus(SYNC, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h44, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("framing_writes", 32'(obs_writes.size()), 32'd0);
    checkOutput("framing_error", 32'(error), 32'd1);
    checkOutput("framing_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("framing_loading", 32'(loading), 32'd0);

    // Full depth via LEN=0
    payload.delete();
    for (int i = 0; i < DEPTH; i++) payload.push_back(8'(i));
    send_frame("full", 8'h00, model_sum(), -1);
    checkOutput("full_last_address", 32'(inst_address), 32'(DEPTH - 1));

    // Randomized frames, some longer than the memory, some corrupted
    for (int f = 0; f < 6; f++) begin
      len = (f == 2) ? 140 : int'($urandom_range(1, 12));
      payload.delete();
      for (int i = 0; i < len; i++) payload.push_back(8'($urandom_range(0, 255)));
      csum = model_sum();
      if ($urandom_range(0, 2) == 0) begin
        flip = 8'd1 << $urandom_range(0, 7);
        csum = csum ^ flip;
      end
      send_frame($sformatf("rand%0d", f), 8'(len), csum, -1);
    end

    // Good frame with a one-cycle rx glitch between data bytes
    payload = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    send_frame("glitch", 8'h02, model_sum(), 0);

    // Restart from RUN: core goes back into reset once the sync byte lands
    obs_writes.delete();
    applyStimulus(SYNC, 1'b1);
    checkOutput("restart_cpu_before", 32'(cpu_rst_n), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("restart_cpu_after", 32'(cpu_rst_n), 32'd0);
    checkOutput("restart_loading", 32'(loading), 32'd1);
    applyStimulus(8'h05, 1'b1);
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    checkOutput("middata_writes", 32'(obs_writes.size()), 32'd2);

    // Reset in the middle of a data character
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("midreset_inst_we", 32'(inst_we), 32'd0);
    checkOutput("midreset_loading", 32'(loading), 32'd0);
    checkOutput("midreset_error", 32'(error), 32'd0);
    checkOutput("midreset_inst_address", 32'(inst_address), 32'd0);
    checkOutput("midreset_inst_data", 32'(inst_data), 32'd0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("postreset_loading", 32'(loading), 32'd0);

    // Loader works normally after the aborted frame
    payload.delete();
    for (int i = 0; i < 5; i++) payload.push_back(8'($urandom_range(0, 255)));
    send_frame("after_reset", 8'h05, model_sum(), -1);

    checkOutput("we_outside_loading", 32'(we_outside), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
